// File: rtl/op_dispatcher_if.sv
// Bundle of the operand stream, core start/busy handshake and result stream
// seen by op_dispatcher. The slave modport is the dispatcher side.
interface op_dispatcher_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
);
    localparam int PW = $clog2(DEPTH) + 1;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_a;
    logic [DATA_W-1:0] in_b;

    logic              core_start;
    logic [DATA_W-1:0] core_inA;
    logic [DATA_W-1:0] core_inB;
    logic              core_busy;
    logic [DATA_W-1:0] core_out;

    logic              res_valid;
    logic              res_ready;
    logic [DATA_W-1:0] res_a;
    logic [DATA_W-1:0] res_b;
    logic [DATA_W-1:0] res_out;

    logic [PW-1:0]     pending;

    modport slave (
        input  in_valid, in_a, in_b, core_busy, core_out, res_ready,
        output in_ready, core_start, core_inA, core_inB,
               res_valid, res_a, res_b, res_out, pending
    );

    modport master (
        output in_valid, in_a, in_b, core_busy, core_out, res_ready,
        input  in_ready, core_start, core_inA, core_inB,
               res_valid, res_a, res_b, res_out, pending
    );
endinterface

// File: rtl/op_dispatcher.sv
// Operand FIFO plus start/busy sequencer feeding a multicycle core; returns
// each core result with its operands through a single-entry result slot.
module op_dispatcher #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int GUARD  = 4
) (
    input logic          clk,
    input logic          rst,
    op_dispatcher_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int GW = $clog2(GUARD + 1);
    localparam logic [PW-1:0] FULL = PW'(DEPTH);

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } pair_t;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_HI, WAIT_LO, CAPTURE} state_t;

    state_t            state, nstate;
    pair_t             mem [DEPTH];
    logic [AW-1:0]     wp, rp;
    logic [PW-1:0]     count;
    logic              push, go;
    logic [GW-1:0]     gcnt;
    logic [DATA_W-1:0] ina_q, inb_q, res_a_q, res_b_q, res_out_q;
    logic              res_valid_q;
    logic              start_c;

    // No bypass: a full FIFO refuses input even in a cycle that pops.
    assign bus.in_ready = (count != FULL);
    assign push         = bus.in_valid && bus.in_ready;
    // The busy term keeps us off a core still running from before a reset.
    assign go = (state == IDLE) && (count != '0) && !res_valid_q && !bus.core_busy;

    always_ff @(posedge clk) begin
        if (push) mem[wp] <= '{a: bus.in_a, b: bus.in_b};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (push) wp <= wp + AW'(1);
            if (go)   rp <= rp + AW'(1);
            count <= count + PW'(push) - PW'(go);
        end
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= nstate;
    end

    // FSM: next state
    always_comb begin
        nstate = state;
        case (state)
            IDLE:    if (go) nstate = ISSUE;
            ISSUE:   nstate = WAIT_HI;
            WAIT_HI: begin
                // gcnt counts cycles since the start pulse; give up at GUARD.
                if (bus.core_busy)                nstate = WAIT_LO;
                else if (gcnt >= GW'(GUARD - 1))  nstate = CAPTURE;
            end
            WAIT_LO: if (!bus.core_busy) nstate = CAPTURE;
            CAPTURE: nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        start_c = (state == ISSUE);
    end

    always_ff @(posedge clk) begin
        if (!rst)                 gcnt <= '0;
        else if (state == ISSUE)  gcnt <= GW'(1);
        else if (state == WAIT_HI) gcnt <= gcnt + GW'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ina_q       <= '0;
            inb_q       <= '0;
            res_a_q     <= '0;
            res_b_q     <= '0;
            res_out_q   <= '0;
            res_valid_q <= 1'b0;
        end else begin
            if (go) begin
                ina_q <= mem[rp].a;
                inb_q <= mem[rp].b;
            end
            if (state == CAPTURE) begin
                res_out_q   <= bus.core_out;
                res_a_q     <= ina_q;
                res_b_q     <= inb_q;
                res_valid_q <= 1'b1;
            end else if (res_valid_q && bus.res_ready) begin
                res_valid_q <= 1'b0;
            end
        end
    end

    assign bus.core_start = start_c;
    assign bus.core_inA   = ina_q;
    assign bus.core_inB   = inb_q;
    assign bus.res_valid  = res_valid_q;
    assign bus.res_a      = res_a_q;
    assign bus.res_b      = res_b_q;
    assign bus.res_out    = res_out_q;
    assign bus.pending    = count;
endmodule
